uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges N_REQ byte-stream requesters onto one UART transmitter.
// The grant stays with one requester for a whole packet; an optional header byte carries its index.
module uart_tx_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N_REQ     = 4,
    parameter bit          HEADER_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic [N_REQ*WIDTH-1:0] i_req_data,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ-1:0]       i_req_last,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic [WIDTH-1:0]       o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic [N_REQ-1:0]       o_grant,
    output logic                   o_busy
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    generate
        if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
            $error("uart_tx_arbiter: N_REQ must be in 2..16");
        end
        if (WIDTH < IdxW) begin : g_bad_width
            $error("uart_tx_arbiter: WIDTH too small to hold a requester index");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPass
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   winner;
    logic [N_REQ-1:0]  owner_oh;
    logic [WIDTH-1:0]  owner_lane;
    logic              owner_valid;
    logic              owner_last;
    logic              pass_xfer;

    assign owner_oh    = N_REQ'(1) << owner_q;
    assign owner_lane  = i_req_data[owner_q*WIDTH +: WIDTH];
    assign owner_valid = i_req_valid[owner_q];
    assign owner_last  = i_req_last[owner_q];
    assign pass_xfer   = (state_q == StPass) && owner_valid && i_tx_ready;

    // Search starts one past the last packet's owner so every requester gets a turn.
    always_comb begin
        logic                found;
        logic [IdxW-1:0]     cand;
        int unsigned         sum;
        found  = 1'b0;
        winner = ptr_q;
        cand   = '0;
        sum    = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            sum  = (32'(ptr_q) + i) % N_REQ;
            cand = IdxW'(sum);
            if (!found && i_req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= IdxW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|i_req_valid) begin
                    owner_d = winner;
                    state_d = HEADER_EN ? StHeader : StPass;
                end
            end
            StHeader: begin
                if (i_tx_ready) begin
                    state_d = StPass;
                end
            end
            StPass: begin
                // The pointer only advances once the whole packet has gone out.
                if (pass_xfer && owner_last) begin
                    state_d = StIdle;
                    ptr_d   = owner_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;
        o_req_ready = '0;
        o_grant     = '0;
        o_busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StHeader: begin
                o_busy     = 1'b1;
                o_grant    = owner_oh;
                o_tx_valid = 1'b1;
                o_tx_data  = WIDTH'(owner_q);
            end
            StPass: begin
                o_busy      = 1'b1;
                o_grant     = owner_oh;
                o_tx_valid  = owner_valid;
                o_tx_data   = owner_valid ? owner_lane : '0;
                o_req_ready = i_tx_ready ? owner_oh : '0;
            end
            default: begin
            end
        endcase
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (i_reset)
        $onehot0(o_grant));
    a_ready_only_owner : assert property (@(posedge clk) disable iff (i_reset)
        (o_req_ready & ~o_grant) == '0);
    a_data_zero_idle : assert property (@(posedge clk) disable iff (i_reset)
        !o_tx_valid |-> (o_tx_data == '0));
    a_busy_matches_grant : assert property (@(posedge clk) disable iff (i_reset)
        o_busy == (|o_grant));

endmodule
